ui_input_conditioner: RTL and testbench

- Parametrised multi-channel successor to the per-button trigger smoother, intended to replace the row of single-channel smoother instances in the MusicBox top level.
- Each channel provides:
  - 2-flop synchroniser
  - per-channel polarity normalisation
  - counter-based debounce
  - single-cycle rise and fall pulses
  - a long-press pulse
  - a wrapping press counter
- Consumers (keys, song select, record/playback FSMs) use the pulses and never take a button as a clock.

---
 rtl/ui_input_pkg.sv | 33 +++
 rtl/ui_conditioner_channel.sv | 117 +++++++++++
 rtl/ui_input_conditioner.sv | 44 ++++
 tb/tb_ui_input_conditioner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ui_input_pkg.sv
// Shared constants for the UI input conditioner.
// Holds the default 50 MHz timing, the counter-width helper and the
// MusicBox channel map.
package ui_input_pkg;

  // 10 ms of stable samples at 50 MHz
  localparam int unsigned STABLE_10MS_AT_50MHZ = 500000;
  // 1 s hold at 50 MHz
  localparam int unsigned LONG_1S_AT_50MHZ     = 50000000;

  // MusicBox wiring: which conditioner channel carries which control
  typedef enum int unsigned {
    KEY0       = 0,
    KEY1       = 1,
    KEY2       = 2,
    KEY3       = 3,
    KEY4       = 4,
    KEY5       = 5,
    PLAY_SONG0 = 6,
    PLAY_SONG1 = 7,
    MAKE_REC   = 8,
    PLAY_REC   = 9
  } musicBoxChannel_e;

  localparam int unsigned MUSICBOX_CHANNELS = 10;

  // A counter that must reach terminalCount gets $clog2(terminalCount)+1 bits.
  // This always leaves headroom, so no counter ever needs an overflow path.
  function automatic int unsigned counterWidth(input int unsigned terminalCount);
    return $clog2(terminalCount) + 1;
  endfunction

endpackage

// File: rtl/ui_conditioner_channel.sv
// One conditioner channel.
// The pin passes through a 2-flop synchroniser and polarity normalisation,
// then a counter debounce. The debounced level drives registered rise/fall
// pulses, a long-press pulse and a wrapping press counter.
module ui_conditioner_channel
  import ui_input_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_10MS_AT_50MHZ,
  parameter int unsigned LONG_CYCLES   = LONG_1S_AT_50MHZ,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned COUNT_W       = 8
) (
  input  logic               clock_50Mhz,
  input  logic               reset,
  input  logic               rawPin,
  input  logic               clearCount,
  output logic               level,
  output logic               risePulse,
  output logic               fallPulse,
  output logic               longPulse,
  output logic [COUNT_W-1:0] pressCount
);

  // Debounce counter terminal count is STABLE_CYCLES-1.
  localparam int unsigned      DEB_W    = counterWidth(STABLE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(STABLE_CYCLES - 1);

  // Hold counter saturates at LONG_CYCLES.
  localparam int unsigned       HOLD_W    = counterWidth(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);

  logic [1:0]        syncQ;
  logic              normSample;
  logic              differs;
  logic              debDone;
  logic [DEB_W-1:0]  debCnt;
  logic              levelQ;
  logic [HOLD_W-1:0] holdCnt;

  // Synchroniser.
  // Reset loads the inactive pin level, so releasing reset with the button
  // idle cannot look like an edge.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      syncQ <= {2{ACTIVE_LOW}};
    end else begin
      syncQ <= {syncQ[0], rawPin};
    end
  end

  // After normalisation, 1 always means pressed.
  assign normSample = syncQ[1] ^ ACTIVE_LOW;
  assign differs    = (normSample != levelQ);
  // Last disagreeing sample of a qualifying run: the level flips on this edge.
  assign debDone    = differs && (debCnt == DEB_LAST);

  // Debounce: count consecutive disagreeing samples. Any agreeing sample
  // restarts the count.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      debCnt <= '0;
      levelQ <= 1'b0;
    end else if (!differs) begin
      debCnt <= '0;
    end else if (debDone) begin
      debCnt <= '0;
      levelQ <= ~levelQ;
    end else begin
      debCnt <= debCnt + DEB_W'(1);
    end
  end

  // Edge pulses are registered alongside the level flip, so each pulse is
  // high in the first cycle the new level is visible.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      risePulse <= 1'b0;
      fallPulse <= 1'b0;
    end else begin
      risePulse <= debDone && !levelQ;
      fallPulse <= debDone && levelQ;
    end
  end

  // Hold timer: runs while the level is pressed and saturates at
  // LONG_CYCLES, so the long pulse fires only once per press.
  always_ff @(posedge clock_50Mhz) begin
    if (reset || !levelQ) begin
      holdCnt <= '0;
    end else if (holdCnt != HOLD_LAST) begin
      holdCnt <= holdCnt + HOLD_W'(1);
    end
  end

  // The long pulse lands in the same cycle the hold timer reads LONG_CYCLES.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      longPulse <= 1'b0;
    end else begin
      longPulse <= levelQ && (holdCnt == HOLD_PRE);
    end
  end

  // Press counter: wraps naturally.
  // Clear wins over a press that lands on the same edge.
  always_ff @(posedge clock_50Mhz) begin
    if (reset || clearCount) begin
      pressCount <= '0;
    end else if (debDone && !levelQ) begin
      pressCount <= pressCount + COUNT_W'(1);
    end
  end

  assign level = levelQ;

endmodule

// File: rtl/ui_input_conditioner.sv
// Multi-channel button/GPIO conditioner.
// Each channel is independent; this level only fans out clear_counts and
// packs the per-channel outputs.
module ui_input_conditioner
  import ui_input_pkg::*;
#(
  parameter int unsigned                 NUM_CHANNELS    = MUSICBOX_CHANNELS,
  parameter int unsigned                 STABLE_CYCLES   = STABLE_10MS_AT_50MHZ,
  parameter int unsigned                 LONG_CYCLES     = LONG_1S_AT_50MHZ,
  parameter logic [NUM_CHANNELS-1:0]     ACTIVE_LOW_MASK = '1,
  parameter int unsigned                 COUNT_W         = 8
) (
  input  logic                            clock_50Mhz,
  input  logic                            reset,
  input  logic [NUM_CHANNELS-1:0]         raw_in,
  input  logic                            clear_counts,
  output logic [NUM_CHANNELS-1:0]         level_out,
  output logic [NUM_CHANNELS-1:0]         rise_pulse,
  output logic [NUM_CHANNELS-1:0]         fall_pulse,
  output logic [NUM_CHANNELS-1:0]         long_pulse,
  output logic [NUM_CHANNELS*COUNT_W-1:0] press_count
);

  // One conditioner per channel. Channel 0 goes in the LSBs of press_count.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : gChan
    ui_conditioner_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW_MASK[ch]),
      .COUNT_W       (COUNT_W)
    ) uChan (
      .clock_50Mhz (clock_50Mhz),
      .reset       (reset),
      .rawPin      (raw_in[ch]),
      .clearCount  (clear_counts),
      .level       (level_out[ch]),
      .risePulse   (rise_pulse[ch]),
      .fallPulse   (fall_pulse[ch]),
      .longPulse   (long_pulse[ch]),
      .pressCount  (press_count[ch*COUNT_W +: COUNT_W])
    );
  end

endmodule

// File: tb/tb_ui_input_conditioner.sv
// Bench for ui_input_conditioner.
// A reference model predicts every output each cycle from the pin history;
// a monitor compares the DUT against those predictions.
module tb_ui_input_conditioner;

  localparam int          NUM    = 2;
  localparam int          STABLE = 4;
  localparam int          LONG   = 20;
  localparam int          CW     = 3;
  localparam logic [1:0]  MASK   = 2'b01;
  localparam int          OUT_W  = 4 * NUM + NUM * CW;

  // ---------------- clock / reset ----------------
  logic              clock_50Mhz = 1'b0;
  logic              reset = 1'b1;
  logic [NUM-1:0]    raw_in = MASK;
  logic              clear_counts = 1'b0;
  logic [NUM-1:0]    level_out, rise_pulse, fall_pulse, long_pulse;
  logic [NUM*CW-1:0] press_count;

  always #5 clock_50Mhz = ~clock_50Mhz;

  ui_input_conditioner #(
    .NUM_CHANNELS    (NUM),
    .STABLE_CYCLES   (STABLE),
    .LONG_CYCLES     (LONG),
    .ACTIVE_LOW_MASK (MASK),
    .COUNT_W         (CW)
  ) dut (
    .clock_50Mhz  (clock_50Mhz),
    .reset        (reset),
    .raw_in       (raw_in),
    .clear_counts (clear_counts),
    .level_out    (level_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  // ---------------- scoreboard state ----------------
  logic [OUT_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Pin values reach the debouncer two edges after they are sampled.
  // A level flips once the last STABLE normalised samples all disagree with it.
  logic [NUM-1:0] pinQ[$];
  logic [NUM-1:0] normQ[$];
  logic [NUM-1:0] mLevel = '0;
  int             mCount[NUM];
  int             riseEdge[NUM];
  int             edgeNo = 0;

  task automatic modelStep();
    logic [NUM-1:0]    sample, prev, rise, fall, lng;
    logic [NUM*CW-1:0] cnts;
    bit                allDiffer;
    edgeNo++;
    rise = '0;
    fall = '0;
    lng  = '0;
    if (reset) begin
      pinQ.delete();
      pinQ.push_back(MASK);
      pinQ.push_back(MASK);
      normQ.delete();
      mLevel = '0;
      for (int ch = 0; ch < NUM; ch++) begin
        mCount[ch]   = 0;
        riseEdge[ch] = -1000000;
      end
    end else begin
      prev   = mLevel;
      sample = pinQ.pop_front();
      pinQ.push_back(raw_in);
      normQ.push_back(sample ^ MASK);
      if (normQ.size() > STABLE) void'(normQ.pop_front());
      for (int ch = 0; ch < NUM; ch++) begin
        allDiffer = (normQ.size() == STABLE);
        for (int k = 0; k < normQ.size(); k++)
          if (normQ[k][ch] == prev[ch]) allDiffer = 0;
        if (prev[ch] && (edgeNo - riseEdge[ch] == LONG)) lng[ch] = 1'b1;
        if (allDiffer) begin
          if (prev[ch]) begin
            fall[ch] = 1'b1;
          end else begin
            rise[ch]     = 1'b1;
            riseEdge[ch] = edgeNo;
          end
          mLevel[ch] = ~prev[ch];
        end
        if (clear_counts) mCount[ch] = 0;
        else if (rise[ch]) mCount[ch] = (mCount[ch] + 1) % (1 << CW);
      end
    end
    for (int ch = 0; ch < NUM; ch++) cnts[ch*CW +: CW] = CW'(mCount[ch]);
    exp_q.push_back({cnts, lng, fall, rise, mLevel});
  endtask

  initial begin
    forever begin
      @(posedge clock_50Mhz);
      modelStep();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [OUT_W-1:0] expVec, actVec;
    forever begin
      @(negedge clock_50Mhz);
      if (exp_q.size() > 0) begin
        expVec = exp_q.pop_front();
        actVec = {press_count, long_pulse, fall_pulse, rise_pulse, level_out};
        checks++;
        if (actVec !== expVec) begin
          errors++;
          $display("FAIL outputs@edge%0d: got lvl=%b rise=%b fall=%b long=%b cnt=%h, expected lvl=%b rise=%b fall=%b long=%b cnt=%h",
                   edgeNo,
                   actVec[NUM-1:0], actVec[2*NUM-1:NUM], actVec[3*NUM-1:2*NUM],
                   actVec[4*NUM-1:3*NUM], actVec[OUT_W-1:4*NUM],
                   expVec[NUM-1:0], expVec[2*NUM-1:NUM], expVec[3*NUM-1:2*NUM],
                   expVec[4*NUM-1:3*NUM], expVec[OUT_W-1:4*NUM]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock_50Mhz);
  endtask

  task automatic setPin(input int ch, input bit pressed);
    raw_in[ch] = pressed ^ MASK[ch];
  endtask

  task automatic pressRelease(input int ch, input int holdCycles, input int gapCycles);
    setPin(ch, 1'b1);
    idle(holdCycles);
    setPin(ch, 1'b0);
    idle(gapCycles);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    // Reset with both pins at their idle level, then 50 quiet cycles.
    idle(3);
    reset = 1'b0;
    idle(50);

    // Single clean press/release on the active-low channel.
    pressRelease(0, 12, 12);

    // Short glitches on ch1 must never qualify.
    repeat (5) pressRelease(1, 3, 1);
    idle(10);

    // Long press on ch1, then a press released before the long threshold.
    pressRelease(1, 30, 12);
    pressRelease(1, 15, 12);

    // Clear, then 8 presses wrap the 3-bit count back to 0.
    clear_counts = 1'b1;
    idle(1);
    clear_counts = 1'b0;
    repeat (8) pressRelease(0, 10, 10);

    // Ninth press with clear_counts sampled on the same edge as the rise.
    setPin(0, 1'b1);
    idle(5);
    clear_counts = 1'b1;
    idle(1);
    clear_counts = 1'b0;
    idle(10);
    setPin(0, 1'b0);
    idle(10);

    // Reset while ch0 is held: the press must re-qualify afterwards.
    setPin(0, 1'b1);
    idle(10);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(12);
    setPin(0, 1'b0);
    idle(12);

    // Randomised pin activity on both channels at once.
    for (int i = 0; i < 150; i++) begin
      raw_in       = NUM'($urandom_range(0, 3));
      clear_counts = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 63) == 0);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 6);
      idle(1);
      clear_counts = 1'b0;
      reset        = 1'b0;
      idle(n);
    end
    raw_in = MASK;
    idle(40);

    // Let the last prediction be consumed, then confirm nothing is left over.
    @(posedge clock_50Mhz);
    #7;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
